training_monitor: RTL and testbench

Receive end of the perceptron training loop. Accepts one (prediction, expected) pair per training sample and returns the binary cross-entropy output gradient to the perceptron's next-layer error port through a 2-stage pipeline. It also scores each sample as correct or incorrect, closes an epoch every SAMPLES_PER_EPOCH samples, and raises converged/stop so the sample sequencer can switch from training to inference.

---
 rtl/fixed_point_pkg.sv | 42 ++++
 rtl/training_monitor_pkg.sv | 6 +
 rtl/bce_grad_pipe.sv | 55 +++++
 rtl/training_monitor.sv | 142 ++++++++++++++
 tb/tb_training_monitor.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Signed Q8.8 fixed-point type with saturating add/sub/divide helpers.
// All arithmetic clamps to the representable range instead of wrapping.
package fixed_point_pkg;
  localparam int FP_W    = 16;
  localparam int FP_FRAC = 8;

  typedef logic signed [FP_W-1:0] sfp;

  localparam sfp ONE     = 16'sd256;
  localparam sfp HALF    = 16'sd128;
  localparam sfp EPSILON = 16'sd1;
  localparam sfp FP_MAX  = 16'sh7fff;
  localparam sfp FP_MIN  = 16'sh8000;

  function automatic sfp sfp_sat(input logic signed [31:0] x);
    if (x > 32'sd32767) return FP_MAX;
    if (x < -32'sd32768) return FP_MIN;
    return x[FP_W-1:0];
  endfunction

  function automatic sfp sfp_add(input sfp a, input sfp b);
    logic signed [31:0] s;
    s = {{16{a[15]}}, a} + {{16{b[15]}}, b};
    return sfp_sat(s);
  endfunction

  function automatic sfp sfp_sub(input sfp a, input sfp b);
    logic signed [31:0] s;
    s = {{16{a[15]}}, a} - {{16{b[15]}}, b};
    return sfp_sat(s);
  endfunction

  // Quotient truncates toward zero; a zero divisor clamps high rather than producing X.
  function automatic sfp sfp_div(input sfp n, input sfp d);
    logic signed [31:0] num;
    logic signed [31:0] den;
    if (d == '0) return FP_MAX;
    num = {{8{n[15]}}, n, 8'h00};
    den = {{16{d[15]}}, d};
    return sfp_sat(num / den);
  endfunction
endpackage

// File: rtl/training_monitor_pkg.sv
// Shared state encoding and saturation bound for the training monitor.
package training_monitor_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} monitor_state_e;

  localparam fixed_point_pkg::sfp SFP_MAX = fixed_point_pkg::FP_MAX;
endpackage

// File: rtl/bce_grad_pipe.sv
// Two-stage binary cross-entropy output-gradient datapath with valid tracking.
// Stage 1 forms both quotients, stage 2 combines them into the gradient.
module bce_grad_pipe
  import fixed_point_pkg::*;
  import training_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  sfp   prediction,
  input  sfp   expected,
  output logic grad_valid,
  output sfp   grad,
  output logic busy
);
  sfp   p_eps;
  sfp   q0_p1_d, q0_p1_q, q1_p1_d, q1_p1_q;
  sfp   grad_p2_d, grad_p2_q;
  logic vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;

  always_comb begin
    p_eps     = sfp_add(prediction, EPSILON);
    q0_p1_d   = (p_eps == '0) ? SFP_MAX : sfp_div(expected, p_eps);
    q1_p1_d   = (p_eps == ONE) ? SFP_MAX
                               : sfp_div(sfp_sub(ONE, expected), sfp_sub(ONE, p_eps));
    vld_p1_d  = in_vld;
    vld_p2_d  = vld_p1_q;
    grad_p2_d = vld_p1_q ? sfp_sub(sfp'(0), sfp_sub(q0_p1_q, q1_p1_q)) : grad_p2_q;
  end

  // Stage 1 boundary: quotient registers load only on an accepted sample
  always_ff @(posedge clk) begin
    if (in_vld) begin
      q0_p1_q <= q0_p1_d;
      q1_p1_q <= q1_p1_d;
    end
  end

  // Stage 2 boundary: gradient and valids; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      grad_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      grad_p2_q <= grad_p2_d;
    end
  end

  assign grad_valid = vld_p2_q;
  assign grad       = grad_p2_q;
  assign busy       = vld_p1_q | vld_p2_q;
endmodule

// File: rtl/training_monitor.sv
// Training monitor: BCE gradient return, per-epoch scoring and convergence/stop control.
// Optional MONITOR_LOSS_ACC_EN adds loss_acc/loss_epoch (|grad| accumulated per epoch).
module training_monitor
  import fixed_point_pkg::*;
  import training_monitor_pkg::*;
#(
  parameter int SAMPLES_PER_EPOCH = 4,
  parameter int MAX_EPOCHS        = 10,
  parameter int CONVERGE_EPOCHS   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid,
  output logic sample_ready,
  input  sfp   prediction,
  input  sfp   expected,
  output logic grad_valid,
  output sfp   grad,
  output logic [15:0] epoch,
  output logic [$clog2(SAMPLES_PER_EPOCH+1)-1:0] correct_count,
  output logic epoch_done,
  output logic converged,
`ifdef MONITOR_LOSS_ACC_EN
  output sfp   loss_acc,
  output sfp   loss_epoch,
`endif
  output logic stop
);
  localparam int CNT_W = $clog2(SAMPLES_PER_EPOCH + 1);
  localparam int STK_W = $clog2(CONVERGE_EPOCHS + 1);

  monitor_state_e   state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] correct_count_q, correct_count_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic [15:0]      epoch_q, epoch_d;
  logic epoch_done_q, epoch_done_d, converged_q, converged_d, stop_q, stop_d;
  logic accept, correct_now, close, full, conv_hit, max_hit, pipe_busy;

  bce_grad_pipe u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (accept),
    .prediction (prediction),
    .expected   (expected),
    .grad_valid (grad_valid),
    .grad       (grad),
    .busy       (pipe_busy)
  );

  always_comb begin
    accept       = sample_valid && sample_ready;
    correct_now  = (prediction > HALF) == (expected > HALF);
    close        = accept && (sample_cnt_q == CNT_W'(SAMPLES_PER_EPOCH - 1));
    sample_cnt_d = sample_cnt_q;
    if (accept) sample_cnt_d = close ? '0 : sample_cnt_q + CNT_W'(1);
    // The score shown with epoch_done clears one cycle later
    correct_count_d = epoch_done_q ? '0 : correct_count_q;
    if (accept && correct_now) correct_count_d = correct_count_d + CNT_W'(1);
    full         = correct_count_d == CNT_W'(SAMPLES_PER_EPOCH);
    conv_hit     = close && full && (streak_q + STK_W'(1) == STK_W'(CONVERGE_EPOCHS));
    max_hit      = close && (epoch_q + 16'd1 == 16'(MAX_EPOCHS));
    streak_d     = streak_q;
    if (close) streak_d = full ? streak_q + STK_W'(1) : '0;
    epoch_d      = close ? epoch_q + 16'd1 : epoch_q;
    epoch_done_d = close;
    converged_d  = converged_q | conv_hit;
    stop_d       = stop_q | conv_hit | max_hit;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (conv_hit || max_hit) state_d = DRAIN;
      DRAIN:   if (!pipe_busy) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    sample_ready = rst_n && (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      sample_cnt_q    <= '0;
      correct_count_q <= '0;
      streak_q        <= '0;
      epoch_q         <= '0;
      epoch_done_q    <= 1'b0;
      converged_q     <= 1'b0;
      stop_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sample_cnt_q    <= sample_cnt_d;
      correct_count_q <= correct_count_d;
      streak_q        <= streak_d;
      epoch_q         <= epoch_d;
      epoch_done_q    <= epoch_done_d;
      converged_q     <= converged_d;
      stop_q          <= stop_d;
    end
  end

  assign epoch         = epoch_q;
  assign correct_count = correct_count_q;
  assign epoch_done    = epoch_done_q;
  assign converged     = converged_q;
  assign stop          = stop_q;

`ifdef MONITOR_LOSS_ACC_EN
  sfp loss_acc_q, loss_acc_d, loss_epoch_q, loss_epoch_d, grad_abs;

  always_comb begin
    grad_abs     = grad[15] ? sfp_sub(sfp'(0), grad) : grad;
    loss_acc_d   = loss_acc_q;
    loss_epoch_d = loss_epoch_q;
    if (epoch_done_q) begin
      loss_epoch_d = loss_acc_q;
      loss_acc_d   = '0;
    end
    if (grad_valid) loss_acc_d = sfp_add(loss_acc_d, grad_abs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_acc_q   <= '0;
      loss_epoch_q <= '0;
    end else begin
      loss_acc_q   <= loss_acc_d;
      loss_epoch_q <= loss_epoch_d;
    end
  end

  assign loss_acc   = loss_acc_q;
  assign loss_epoch = loss_epoch_q;
`else
  // Default build carries no loss accumulator.
`endif
endmodule

// File: tb/tb_training_monitor.sv
// Directed bench for training_monitor: gradient values/latency, epoch scoring,
// convergence, max-epoch stop, divide guard and mid-flight reset.
module tb_training_monitor;
  import fixed_point_pkg::*;
  import training_monitor_pkg::*;

  logic        clk, rst_n, sample_valid, sample_ready;
  sfp          prediction, expected, grad;
  logic        grad_valid, epoch_done, converged, stop;
  logic [15:0] epoch;
  logic [2:0]  correct_count;
`ifdef MONITOR_LOSS_ACC_EN
  sfp          loss_acc, loss_epoch;
`endif

  training_monitor #(
    .SAMPLES_PER_EPOCH (4),
    .MAX_EPOCHS        (10),
    .CONVERGE_EPOCHS   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .prediction    (prediction),
    .expected      (expected),
    .grad_valid    (grad_valid),
    .grad          (grad),
    .epoch         (epoch),
    .correct_count (correct_count),
    .epoch_done    (epoch_done),
    .converged     (converged),
`ifdef MONITOR_LOSS_ACC_EN
    .loss_acc      (loss_acc),
    .loss_epoch    (loss_epoch),
`endif
    .stop          (stop)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gv_cnt  = 0;
  int ed_cnt  = 0;
  int last_grad = 0;
  int gv_mark, tol_ok;
  int acc_q[$];
  int grad_q[$];

  // AND-gate epoch: prediction 0.1/0.1/0.1/0.9 (26/26/26/230), all scored correct
  sfp and_p[4] = '{16'sd26, 16'sd26, 16'sd26, 16'sd230};
  sfp and_e[4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd256};
  int and_g[4] = '{286, 286, 286, -283};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample for the coming edge; remember its edge number and expected grad
  task automatic drive(input sfp p, input sfp e, input int g);
    sample_valid = 1'b1;
    prediction   = p;
    expected     = e;
    if (sample_ready) begin
      acc_q.push_back(cyc + 1);
      grad_q.push_back(g);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    acc_q.delete();
    grad_q.delete();
    repeat (2) @(negedge clk);
    check_val("rst_ready", int'(sample_ready), 0);
    check_val("rst_gvalid", int'(grad_valid), 0);
    check_val("rst_grad", int'(grad), 0);
    check_val("rst_epoch", int'(epoch), 0);
    check_val("rst_cc", int'(correct_count), 0);
    check_val("rst_edone", int'(epoch_done), 0);
    check_val("rst_conv", int'(converged), 0);
    check_val("rst_stop", int'(stop), 0);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready", int'(sample_ready), 1);
  endtask

  // Gradient scoreboard; grad_valid is visible in cycle N+2, i.e. right after edge N+1
  always @(posedge clk) begin
    #1;
    if (grad_valid) begin
      gv_cnt++;
      last_grad = int'(grad);
      check_val("grad_pending", int'(acc_q.size() > 0), 1);
      if (acc_q.size() > 0) begin
        check_val("grad_lat", cyc, acc_q.pop_front() + 1);
        check_val("grad_val", int'(grad), grad_q.pop_front());
      end
    end
    if (epoch_done) ed_cnt++;
  end

  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b0;
    prediction = '0;
    expected = '0;

    // Two perfect AND epochs back to back -> convergence
    do_reset();
    ed_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) check_val("cc_before_close", int'(correct_count), 3);
      if (i == 4) begin
        check_val("e1_edone", int'(epoch_done), 1);
        check_val("e1_epoch", int'(epoch), 1);
        check_val("e1_cc", int'(correct_count), 4);
        check_val("e1_edcnt", ed_cnt, 1);
        check_val("e1_stop", int'(stop), 0);
      end
      if (i == 5) begin
        check_val("cc_cleared", int'(correct_count), 1);
        check_val("e1_edone_pulse", int'(epoch_done), 0);
      end
      if (i == 7) gv_mark = gv_cnt;
      drive(and_p[i % 4], and_e[i % 4], and_g[i % 4]);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check_val("conv_conv", int'(converged), 1);
    check_val("conv_stop", int'(stop), 1);
    check_val("conv_ready", int'(sample_ready), 0);
    check_val("conv_epoch", int'(epoch), 2);
    check_val("conv_edcnt", ed_cnt, 2);
    repeat (4) @(negedge clk);
    check_val("trail_pulses", gv_cnt - gv_mark, 2);
    check_val("drain_empty", acc_q.size(), 0);
    check_val("fsm_done", int'(dut.state_q), int'(DONE));
    gv_mark = gv_cnt;
    drive(and_p[0], and_e[0], and_g[0]);
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    check_val("done_ready", int'(sample_ready), 0);
    check_val("done_epoch", int'(epoch), 2);
    check_val("done_no_grad", gv_cnt - gv_mark, 0);

    // Gradient at prediction = HALF, expected = ONE
    do_reset();
    @(negedge clk);
    drive(16'sd128, 16'sd256, -508);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    tol_ok = ((last_grad - (-(65536 / 129))) <= 2 && (last_grad - (-(65536 / 129))) >= -2) ? 1 : 0;
    check_val("half_tol", tol_ok, 1);
    check_val("grad_held", int'(grad), -508);

    // Divide guard: p + eps == ONE
    do_reset();
    @(negedge clk);
    drive(16'sd255, 16'sd0, 32767);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("guard_grad", int'(grad), 32767);
    check_val("guard_nox", int'($isunknown(grad)), 0);

    // Always wrong -> stop at MAX_EPOCHS without convergence
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 39) begin
        check_val("max_stop_early", int'(stop), 0);
        check_val("max_epoch9", int'(epoch), 9);
      end
      drive(16'sd26, 16'sd256, -2427);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check_val("max_stop", int'(stop), 1);
    check_val("max_conv", int'(converged), 0);
    check_val("max_epoch", int'(epoch), 10);
    check_val("max_ready", int'(sample_ready), 0);
    repeat (4) @(negedge clk);
    check_val("max_drain", acc_q.size(), 0);

    // Reset one cycle after acceptance discards the in-flight gradient
    do_reset();
    @(negedge clk);
    drive(16'sd26, 16'sd0, 286);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    acc_q.delete();
    grad_q.delete();
    gv_mark = gv_cnt;
    @(negedge clk);
    check_val("mid_rst_ready", int'(sample_ready), 0);
    check_val("mid_rst_gvalid", int'(grad_valid), 0);
    check_val("mid_rst_grad", int'(grad), 0);
    check_val("mid_rst_cc", int'(correct_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mid_rel_ready", int'(sample_ready), 1);
    repeat (4) @(negedge clk);
    check_val("mid_no_grad", gv_cnt - gv_mark, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
